// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the BCD entry register.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hF;

  // Indexed [row][col]; col0 is the column driven by o_col_n[0]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    col_decode = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD entry register: decimal keys shift in from the right,
// A clears, B drops the least significant digit, other keys leave it alone.
module bcd_entry_reg
  import keypad_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_key,
  output logic [3:0] o_bcd0,
  output logic [3:0] o_bcd1,
  output logic [3:0] o_bcd2,
  output logic [3:0] o_bcd3
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_bcd0 <= 4'd0;
      o_bcd1 <= 4'd0;
      o_bcd2 <= 4'd0;
      o_bcd3 <= 4'd0;
    end else if (i_load) begin
      if (i_key <= 4'd9) begin
        o_bcd3 <= o_bcd2;
        o_bcd2 <= o_bcd1;
        o_bcd1 <= o_bcd0;
        o_bcd0 <= i_key;
      end else if (i_key == KEY_CLR) begin
        o_bcd0 <= 4'd0;
        o_bcd1 <= 4'd0;
        o_bcd2 <= 4'd0;
        o_bcd3 <= 4'd0;
      end else if (i_key == KEY_BS) begin
        o_bcd0 <= o_bcd1;
        o_bcd1 <= o_bcd2;
        o_bcd2 <= o_bcd3;
        o_bcd3 <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce, hex decode and a BCD entry register.
// Columns are driven one-hot-low; rows are synchronized and judged once per dwell.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [3:0] o_col_n,
  input  logic [3:0] i_row_n,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_enter,
  output logic [3:0] o_bcd0,
  output logic [3:0] o_bcd1,
  output logic [3:0] o_bcd2,
  output logic [3:0] o_bcd3
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] dwell_cnt;
  logic          sample_tick;
  kp_state_t     state, state_nxt;
  logic [MW-1:0] match, match_nxt, match_inc;
  logic [MW-1:0] rel, rel_nxt, rel_inc;
  logic [1:0]    col_idx, row_idx, latched_row;
  logic          row_valid, latch_row, advance, accept;
  logic [3:0]    key_nxt;

  assign sample_tick = (dwell_cnt == CW'(SCAN_DIV - 1));
  assign match_inc   = match + 1'b1;
  assign rel_inc     = rel + 1'b1;
  assign key_nxt     = KEYMAP[row_idx][col_idx];

  // Zero or several low rows (chords, ghosting) are treated as no key
  always_comb begin
    row_valid = 1'b1;
    row_idx   = 2'd0;
    case (row_s2)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match;
    rel_nxt   = rel;
    latch_row = 1'b0;
    advance   = 1'b0;
    accept    = 1'b0;
    case (state)
      SCAN: begin
        if (sample_tick) begin
          if (row_valid) begin
            latch_row = 1'b1;
            if (DEBOUNCE_CNT == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
              match_nxt = '0;
            end else begin
              state_nxt = DEBOUNCE;
              match_nxt = MW'(1);
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample_tick) begin
          if (row_valid && (row_idx == latched_row)) begin
            if (match_inc == MW'(DEBOUNCE_CNT)) begin
              accept    = 1'b1;
              state_nxt = HELD;
              match_nxt = '0;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            state_nxt = SCAN;
            match_nxt = '0;
            advance   = 1'b1;
          end
        end
      end
      HELD: begin
        // Release must be seen as consecutive all-high samples; any low restarts it
        if (sample_tick) begin
          if (row_s2 == 4'hF) begin
            if (rel_inc == MW'(DEBOUNCE_CNT)) begin
              state_nxt = SCAN;
              rel_nxt   = '0;
              advance   = 1'b1;
            end else begin
              rel_nxt = rel_inc;
            end
          end else begin
            rel_nxt = '0;
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      row_s1      <= 4'hF;
      row_s2      <= 4'hF;
      dwell_cnt   <= '0;
      state       <= SCAN;
      match       <= '0;
      rel         <= '0;
      latched_row <= 2'd0;
      col_idx     <= 2'd0;
      o_col_n     <= 4'b1110;
      o_key_valid <= 1'b0;
      o_key_code  <= 4'd0;
      o_enter     <= 1'b0;
    end else begin
      row_s1      <= i_row_n;
      row_s2      <= row_s1;
      dwell_cnt   <= sample_tick ? '0 : dwell_cnt + 1'b1;
      state       <= state_nxt;
      match       <= match_nxt;
      rel         <= rel_nxt;
      o_key_valid <= accept;
      o_enter     <= accept && (key_nxt == KEY_ENT);
      if (latch_row) latched_row <= row_idx;
      if (accept) o_key_code <= key_nxt;
      if (advance) begin
        col_idx <= col_idx + 2'd1;
        o_col_n <= col_decode(col_idx + 2'd1);
      end
    end
  end

  bcd_entry_reg u_entry (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (accept),
    .i_key   (key_nxt),
    .o_bcd0  (o_bcd0),
    .o_bcd1  (o_bcd1),
    .o_bcd2  (o_bcd2),
    .o_bcd3  (o_bcd3)
  );

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry using a combinational keypad model
// that shorts each pressed key's row to its column while that column is driven.
module tb_keypad_bcd_entry;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col_n, row_n;
  logic       key_valid, enter;
  logic [3:0] key_code, bcd0, bcd1, bcd2, bcd3;
  logic [15:0] bcd_all;
  logic [15:0] pressed;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int enter_cnt = 0;
  int enter_valid_cnt = 0;

  always #5 clk = ~clk;

  keypad_bcd_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_col_n     (col_n),
    .i_row_n     (row_n),
    .o_key_valid (key_valid),
    .o_key_code  (key_code),
    .o_enter     (enter),
    .o_bcd0      (bcd0),
    .o_bcd1      (bcd1),
    .o_bcd2      (bcd2),
    .o_bcd3      (bcd3)
  );

  assign bcd_all = {bcd3, bcd2, bcd1, bcd0};

  // Pressed-key bit index is row*4 + col
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(pressed[r*4 +: 4] & ~col_n)) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulse_cnt++;
    if (enter) enter_cnt++;
    if (enter && key_valid) enter_valid_cnt++;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] keyMask(input int r, input int c);
    keyMask = 16'h0001 << (r * 4 + c);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int cycles);
    pressed = mask;
    waitCycles(cycles);
  endtask

  task automatic pressKey(input int r, input int c);
    applyStimulus(keyMask(r, c), 120);
    applyStimulus(16'h0000, 80);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Leaves the bench just after the edge on which col_n switched to target
  task automatic alignToCol(input logic [3:0] target, output logic ok);
    int n;
    n = 0;
    while (col_n == target && n < 100) begin waitCycles(1); n++; end
    n = 0;
    while (col_n != target && n < 100) begin waitCycles(1); n++; end
    ok = (col_n == target);
  endtask

  initial begin
    int p0, e0, ev0, n;
    logic ok;

    // Reset aborts a debounce of key 7 already in progress
    rst_n = 1'b0;
    pressed = 16'h0000;
    waitCycles(4);
    rst_n = 1'b1;
    pressed = keyMask(2, 0);
    waitCycles(7);
    rst_n = 1'b0;
    pressed = 16'h0000;
    waitCycles(1);
    checkOutput("t1_col_reset", col_n, 16'h000E);
    checkOutput("t1_valid_reset", key_valid, 16'h0);
    checkOutput("t1_code_reset", key_code, 16'h0);
    checkOutput("t1_enter_reset", enter, 16'h0);
    checkOutput("t1_bcd_reset", bcd_all, 16'h0000);
    rst_n = 1'b1;
    waitCycles(100);
    checkOutput("t1_no_pulse", pulse_cnt, 16'd0);

    // Clean long press of 5 with column frozen while held
    p0 = pulse_cnt;
    applyStimulus(keyMask(1, 1), 60);
    checkOutput("t2_col_held_a", col_n, 16'h000D);
    waitCycles(60);
    checkOutput("t2_col_held_b", col_n, 16'h000D);
    waitCycles(70);
    checkOutput("t2_col_held_c", col_n, 16'h000D);
    waitCycles(10);
    applyStimulus(16'h0000, 80);
    checkOutput("t2_pulses", pulse_cnt - p0, 16'd1);
    checkOutput("t2_code", key_code, 16'h5);
    checkOutput("t2_bcd", bcd_all, 16'h0005);

    // Digit entry, backspace and clear
    p0 = pulse_cnt;
    pressKey(0, 0);
    pressKey(0, 1);
    pressKey(0, 2);
    pressKey(1, 0);
    pressKey(1, 1);
    checkOutput("t3_after_5", bcd_all, 16'h2345);
    pressKey(1, 3);
    checkOutput("t3_after_B", bcd_all, 16'h0234);
    pressKey(0, 3);
    checkOutput("t3_after_A", bcd_all, 16'h0000);
    checkOutput("t3_pulses", pulse_cnt - p0, 16'd7);

    // Key 9 bounce: low, high, then steady low; accept on third consecutive low
    p0 = pulse_cnt;
    alignToCol(4'b1011, ok);
    checkOutput("t4_align_a", ok, 16'h1);
    pressed = keyMask(2, 2);
    waitCycles(4);
    pressed = 16'h0000;
    waitCycles(4);
    pressed = keyMask(2, 2);
    waitCycles(23);
    checkOutput("t4_no_early_pulse", pulse_cnt - p0, 16'd0);
    checkOutput("t4_valid_before", key_valid, 16'h0);
    waitCycles(1);
    checkOutput("t4_valid_at_3rd", key_valid, 16'h1);
    waitCycles(40);
    applyStimulus(16'h0000, 80);
    checkOutput("t4_pulses", pulse_cnt - p0, 16'd1);
    checkOutput("t4_code", key_code, 16'h9);
    checkOutput("t4_bcd", bcd_all, 16'h0009);

    // Single-sample glitch on 9: no pulse, scan resumes at next column
    p0 = pulse_cnt;
    alignToCol(4'b1011, ok);
    checkOutput("t4_align_b", ok, 16'h1);
    pressed = keyMask(2, 2);
    waitCycles(4);
    checkOutput("t4_glitch_frozen", col_n, 16'h000B);
    pressed = 16'h0000;
    waitCycles(4);
    checkOutput("t4_glitch_next_col", col_n, 16'h0007);
    waitCycles(80);
    checkOutput("t4_glitch_no_pulse", pulse_cnt - p0, 16'd0);

    // Chord 2+5 ignored, then enter
    p0 = pulse_cnt;
    applyStimulus(keyMask(0, 1) | keyMask(1, 1), 120);
    applyStimulus(16'h0000, 80);
    checkOutput("t5_chord_no_pulse", pulse_cnt - p0, 16'd0);
    p0 = pulse_cnt;
    e0 = enter_cnt;
    ev0 = enter_valid_cnt;
    pressKey(3, 1);
    checkOutput("t5_pulses", pulse_cnt - p0, 16'd1);
    checkOutput("t5_enter_cycles", enter_cnt - e0, 16'd1);
    checkOutput("t5_enter_with_valid", enter_valid_cnt - ev0, 16'd1);
    checkOutput("t5_code", key_code, 16'hF);
    checkOutput("t5_bcd", bcd_all, 16'h0009);

    // Key 8 with a one-sample low bounce during release
    p0 = pulse_cnt;
    pressed = keyMask(2, 1);
    n = 0;
    while (!key_valid && n < 200) begin waitCycles(1); n++; end
    checkOutput("t6_accept", key_valid, 16'h1);
    waitCycles(8);
    pressed = 16'h0000;
    waitCycles(8);
    pressed = keyMask(2, 1);
    waitCycles(4);
    pressed = 16'h0000;
    waitCycles(11);
    checkOutput("t6_still_held", col_n, 16'h000D);
    waitCycles(1);
    checkOutput("t6_exit_held", col_n, 16'h000B);
    waitCycles(40);
    checkOutput("t6_pulses", pulse_cnt - p0, 16'd1);
    checkOutput("t6_code", key_code, 16'h8);
    checkOutput("t6_bcd", bcd_all, 16'h0098);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
